// File: rtl/chk_pkg.sv
// Shared types for the memory write checker: FSM states, failure codes and
// the table index-width helper.
package chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_EXTRA    = 2'd3
    } fail_code_t;

    // A one-entry table still needs a one-bit index port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/exp_table.sv
// Expected-write table: DEPTH entries of {address, data}, one synchronous
// write port and one asynchronous read port.
module exp_table #(
    parameter int ADR_W  = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADR_W-1:0]  radr,
    output logic [DATA_W-1:0] rdata
);

    logic [ADR_W+DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; entries are only read below the load
    // count, which reset clears, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {wadr, wdata};
        end
    end

    assign {radr, rdata} = mem[raddr];

endmodule

// File: rtl/mem_write_checker.sv
// Checks a CPU write stream against a preloaded table of expected writes.
// Optional watchdog enabled by defining CHK_TIMEOUT_EN.
module mem_write_checker
    import chk_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADR_W   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memEnable,
    input  logic [ADR_W-1:0]           memAdr,
    input  logic [DATA_W-1:0]          memWD,
    input  logic                       expLoad,
    input  logic [ADR_W-1:0]           expAdr,
    input  logic [DATA_W-1:0]          expData,
    input  logic                       start,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 failCode,
    output logic [$clog2(DEPTH+1)-1:0] matchCount,
    output logic [ADR_W-1:0]           failAdr,
    output logic [DATA_W-1:0]          failData
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam bit PARAMS_OK = (DEPTH >= 1) && (TIMEOUT >= 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("mem_write_checker: DEPTH and TIMEOUT must both be >= 1");
    end

    state_t            state;
    fail_code_t        code_q;
    logic [CNT_W-1:0]  loadCount;
    logic [ADR_W-1:0]  rd_adr;
    logic [DATA_W-1:0] rd_data;
    logic              load_ok;
    logic              hit;
    logic              arm;
    logic              wd_expired;

    assign load_ok = (state == ST_IDLE) && expLoad && (loadCount != DEPTH_C);
    assign hit     = (rd_adr == memAdr) && (rd_data == memWD);

    // Start from IDLE also counts an entry being loaded on the same edge.
    assign arm = start && (((state == ST_IDLE) && ((loadCount != '0) || load_ok))
                           || (state == ST_PASS) || (state == ST_FAIL));

    exp_table #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk   (clk),
        .we    (load_ok),
        .waddr (loadCount[IDX_W-1:0]),
        .wadr  (expAdr),
        .wdata (expData),
        .raddr (matchCount[IDX_W-1:0]),
        .radr  (rd_adr),
        .rdata (rd_data)
    );

`ifdef CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    // Cleared outside CHECK (so every start begins at zero) and on each match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if ((state != ST_CHECK) || (memEnable && hit)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end

    assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    assign failCode = code_q;

    // NOTE: all state and outputs use non-blocking assignments so every
    // register updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            loadCount  <= '0;
            matchCount <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            code_q     <= FC_NONE;
            failAdr    <= '0;
            failData   <= '0;
        end else begin
            if (load_ok) begin
                loadCount <= loadCount + ONE_C;
            end

            if (arm) begin
                state      <= ST_CHECK;
                matchCount <= '0;
                busy       <= 1'b1;
                pass       <= 1'b0;
                fail       <= 1'b0;
                code_q     <= FC_NONE;
            end else begin
                case (state)
                    ST_CHECK: begin
                        if (memEnable && hit) begin
                            matchCount <= matchCount + ONE_C;
                            if ((matchCount + ONE_C) == loadCount) begin
                                state <= ST_PASS;
                                busy  <= 1'b0;
                                pass  <= 1'b1;
                            end
                        end else if (memEnable) begin
                            state    <= ST_FAIL;
                            busy     <= 1'b0;
                            fail     <= 1'b1;
                            code_q   <= FC_MISMATCH;
                            failAdr  <= memAdr;
                            failData <= memWD;
                        end else if (wd_expired) begin
                            state    <= ST_FAIL;
                            busy     <= 1'b0;
                            fail     <= 1'b1;
                            code_q   <= FC_TIMEOUT;
                            failAdr  <= '0;
                            failData <= '0;
                        end
                    end
                    ST_PASS: begin
                        if (memEnable) begin
                            state    <= ST_FAIL;
                            pass     <= 1'b0;
                            fail     <= 1'b1;
                            code_q   <= FC_EXTRA;
                            failAdr  <= memAdr;
                            failData <= memWD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a rule-level
// model; a monitor pops and compares after each rising edge.
module tb_mem_write_checker;

    localparam int DATA_W  = 8;
    localparam int ADR_W   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam int P_IDLE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_PASS  = 2;
    localparam int P_FAIL  = 3;

    logic              clk;
    logic              reset;
    logic              memEnable;
    logic [ADR_W-1:0]  memAdr;
    logic [DATA_W-1:0] memWD;
    logic              expLoad;
    logic [ADR_W-1:0]  expAdr;
    logic [DATA_W-1:0] expData;
    logic              start;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        failCode;
    logic [CNT_W-1:0]  matchCount;
    logic [ADR_W-1:0]  failAdr;
    logic [DATA_W-1:0] failData;

    mem_write_checker #(
        .DATA_W  (DATA_W),
        .ADR_W   (ADR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memEnable  (memEnable),
        .memAdr     (memAdr),
        .memWD      (memWD),
        .expLoad    (expLoad),
        .expAdr     (expAdr),
        .expData    (expData),
        .start      (start),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .failCode   (failCode),
        .matchCount (matchCount),
        .failAdr    (failAdr),
        .failData   (failData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int busy;
        int pass;
        int fail;
        int code;
        int mc;
        int fa;
        int fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the checker's rules over a plain array of entries.
    int m_phase;
    int m_ta[DEPTH];
    int m_td[DEPTH];
    int m_loaded;
    int m_matched;
    int m_code;
    int m_fa;
    int m_fd;
    int m_idle;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase   = P_IDLE;
        m_loaded  = 0;
        m_matched = 0;
        m_code    = 0;
        m_fa      = 0;
        m_fd      = 0;
        m_idle    = 0;
    endfunction

    function automatic void model_arm();
        m_phase   = P_CHECK;
        m_matched = 0;
        m_code    = 0;
        m_idle    = 0;
    endfunction

    function automatic void model_step(input bit me, input int ma, input int md,
                                       input bit el, input int ea, input int ed,
                                       input bit st);
        case (m_phase)
            P_IDLE: begin
                if (el && m_loaded < DEPTH) begin
                    m_ta[m_loaded] = ea;
                    m_td[m_loaded] = ed;
                    m_loaded++;
                end
                if (st && m_loaded > 0) model_arm();
            end
            P_CHECK: begin
                if (me && ma == m_ta[m_matched] && md == m_td[m_matched]) begin
                    m_matched++;
                    m_idle = 0;
                    if (m_matched == m_loaded) m_phase = P_PASS;
                end else if (me) begin
                    m_phase = P_FAIL; m_code = 1; m_fa = ma; m_fd = md;
                end else begin
`ifdef CHK_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_phase = P_FAIL; m_code = 2; m_fa = 0; m_fd = 0;
                    end
`endif
                end
            end
            P_PASS: begin
                if (st) model_arm();
                else if (me) begin
                    m_phase = P_FAIL; m_code = 3; m_fa = ma; m_fd = md;
                end
            end
            default: begin
                if (st) model_arm();
            end
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy = (m_phase == P_CHECK) ? 1 : 0;
        e.pass = (m_phase == P_PASS) ? 1 : 0;
        e.fail = (m_phase == P_FAIL) ? 1 : 0;
        e.code = m_code;
        e.mc   = m_matched;
        e.fa   = m_fa;
        e.fd   = m_fd;
        return e;
    endfunction

    task automatic cycle(input bit me, input int ma, input int md,
                         input bit el, input int ea, input int ed, input bit st);
        @(negedge clk);
        memEnable = me;
        memAdr    = ADR_W'(ma);
        memWD     = DATA_W'(md);
        expLoad   = el;
        expAdr    = ADR_W'(ea);
        expData   = DATA_W'(ed);
        start     = st;
        model_step(me, ma, md, el, ea, ed, st);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic load(input int a, input int d);
        cycle(1'b0, 0, 0, 1'b1, a, d, 1'b0);
    endtask

    task automatic arm_start();
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic write(input int a, input int d);
        cycle(1'b1, a, d, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_fail"}, int'(fail), 0);
        check({tag, "_code"}, int'(failCode), 0);
        check({tag, "_mc"}, int'(matchCount), 0);
        check({tag, "_fadr"}, int'(failAdr), 0);
        check({tag, "_fdata"}, int'(failData), 0);
    endtask

    // Asynchronous reset pulse inside the low clock phase, checked before
    // any clock edge can intervene.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero(tag);
        #1 reset = 1'b0;
        model_reset();
        memEnable = 1'b0;
        expLoad   = 1'b0;
        start     = 1'b0;
        model_step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        exp_q.push_back(model_out());
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_busy", int'(busy), e.busy);
            check("sb_pass", int'(pass), e.pass);
            check("sb_fail", int'(fail), e.fail);
            check("sb_code", int'(failCode), e.code);
            check("sb_mc", int'(matchCount), e.mc);
            check("sb_fadr", int'(failAdr), e.fa);
            check("sb_fdata", int'(failData), e.fd);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        memEnable = 1'b0;
        memAdr    = '0;
        memWD     = '0;
        expLoad   = 1'b0;
        expAdr    = '0;
        expData   = '0;
        start     = 1'b0;
        model_reset();
        #12 check_all_zero("por");
        #10 reset = 1'b0;

        // Two-entry success, then an extra write, then re-arm.
        load(8'h10, 4);
        load(8'h11, 9);
        arm_start();
        write(8'h10, 4);
        write(8'h11, 9);
        settle();
        check("ok_pass", int'(pass), 1);
        check("ok_mc", int'(matchCount), 2);
        check("ok_code", int'(failCode), 0);
        write(8'h30, 1);
        settle();
        check("extra_fail", int'(fail), 1);
        check("extra_code", int'(failCode), 3);
        check("extra_fadr", int'(failAdr), 8'h30);
        check("extra_fdata", int'(failData), 1);
        arm_start();
        settle();
        check("rearm_busy", int'(busy), 1);
        check("rearm_code", int'(failCode), 0);
        check("rearm_mc", int'(matchCount), 0);

        // Mismatch on data only; captured values held while in FAIL.
        do_reset("rst_a");
        load(8'h20, 4);
        arm_start();
        write(8'h20, 5);
        settle();
        check("mm_fail", int'(fail), 1);
        check("mm_code", int'(failCode), 1);
        check("mm_fadr", int'(failAdr), 8'h20);
        check("mm_fdata", int'(failData), 5);
        check("mm_mc", int'(matchCount), 0);
        write(8'h55, 7);
        idle_cycle();
        settle();
        check("mm_hold_fadr", int'(failAdr), 8'h20);
        check("mm_hold_code", int'(failCode), 1);

        // Table full: fifth load ignored, so four matches reach PASS.
        do_reset("rst_b");
        for (int i = 0; i < 5; i++) load(8'h40 + i, 8'hA0 + i);
        arm_start();
        for (int i = 0; i < 3; i++) write(8'h40 + i, 8'hA0 + i);
        settle();
        check("full_busy", int'(busy), 1);
        check("full_mc3", int'(matchCount), 3);
        write(8'h43, 8'hA3);
        settle();
        check("full_pass", int'(pass), 1);
        check("full_mc4", int'(matchCount), 4);
        arm_start();
        write(8'h40, 8'hA0);
        do_reset("rst_mid");
        arm_start();
        write(8'h40, 8'hA0);
        settle();
        check("noload_busy", int'(busy), 0);
        check("noload_mc", int'(matchCount), 0);

        // Load and start on the same edge.
        cycle(1'b0, 0, 0, 1'b1, 8'h7E, 8'h3C, 1'b1);
        settle();
        check("same_busy", int'(busy), 1);
        write(8'h7E, 8'h3C);
        settle();
        check("same_pass", int'(pass), 1);

`ifdef CHK_TIMEOUT_EN
        do_reset("rst_to");
        load(8'h01, 8'h02);
        arm_start();
        settle();
        check("to_busy", int'(busy), 1);
        repeat (TIMEOUT - 1) idle_cycle();
        settle();
        check("to_early", int'(fail), 0);
        idle_cycle();
        settle();
        check("to_fail", int'(fail), 1);
        check("to_code", int'(failCode), 2);
        check("to_fadr", int'(failAdr), 0);
`endif

        // Randomized traffic, biased by the model's phase.
        do_reset("rst_rand");
        for (int n = 0; n < 1500; n++) begin
            bit me, el, st;
            int ma, md, ea, ed;
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rst_r");
                continue;
            end
            ma = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            ea = $urandom_range(0, 3);
            ed = $urandom_range(0, 3);
            me = 1'b0; el = 1'b0; st = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    el = ($urandom_range(0, 1) == 1);
                    st = ($urandom_range(0, 3) == 0);
                    me = ($urandom_range(0, 4) == 0);
                end
                P_CHECK: begin
                    me = ($urandom_range(0, 4) < 3);
                    el = ($urandom_range(0, 4) == 0);
                    if ($urandom_range(0, 99) < 85) begin
                        ma = m_ta[m_matched];
                        md = m_td[m_matched];
                    end
                end
                default: begin
                    st = ($urandom_range(0, 9) < 3);
                    me = ($urandom_range(0, 9) < 3);
                end
            endcase
            cycle(me, ma, md, el, ea, ed, st);
        end

        repeat (3) idle_cycle();
        settle();
        #5;
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory write-data width.
REQ-002 SHALL have parameter ADR_W, default 8, memory address width.
REQ-003 SHALL have parameter DEPTH, default 4, number of expected-write table entries (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 1024, watchdog cycle limit (used only with CHK_TIMEOUT_EN).
REQ-005 SHALL have ports: clk  in  1  system clock, rising edge active.
REQ-006 SHALL have: reset  in  1  one clock; reset is asynchronous and active-high.
REQ-007 SHALL have: memEnable  in  1  CPU memory write strobe.
REQ-008 SHALL have: memAdr  in  ADR_W  CPU write address; memWD  in  DATA_W  CPU write data.
REQ-009 SHALL have: expLoad  in  1  append entry; expAdr  in  ADR_W; expData  in  DATA_W  expected address and data.
REQ-010 SHALL have: start  in  1  arm checking.
REQ-011 SHALL have: busy  out  1  in CHECK; pass  out  1  sticky success; fail  out  1  sticky failure.
REQ-012 SHALL have: failCode  out  2  0 NONE, 1 MISMATCH, 2 TIMEOUT, 3 EXTRA.
REQ-013 SHALL have: matchCount  out  $clog2(DEPTH+1)  writes matched; failAdr  out  ADR_W; failData  out  DATA_W  offending write.

Function
REQ-014 SHALL implement states IDLE, CHECK, PASS, FAIL; all outputs registered.
REQ-015 SHALL, in IDLE, store expLoad entry at index loadCount and increment loadCount; expLoad with loadCount==DEPTH ignored.
REQ-016 SHALL ignore expLoad outside IDLE and memEnable in IDLE.
REQ-017 SHALL, on start in IDLE with loadCount>0 (including an entry loaded same cycle), enter CHECK with matchCount=0; start with loadCount==0 ignored.
REQ-018 SHALL, in CHECK, compare each sampled memEnable write against entry[matchCount] (address and data both equal).
REQ-019 SHALL on match increment matchCount; if it becomes loadCount, enter PASS.
REQ-020 SHALL on mismatch enter FAIL, failCode=1, capture memAdr/memWD into failAdr/failData.
REQ-021 SHALL, on memEnable in PASS, enter FAIL with failCode=3 and capture the write.
REQ-022 SHALL treat FAIL as terminal until start; start in PASS or FAIL re-enters CHECK, matchCount=0, failCode=0, table and loadCount kept.
REQ-023 SHALL assert pass/fail/busy/failCode the cycle after the deciding clock edge (latency 1).
REQ-024 SHALL keep matchCount and failAdr/failData stable in PASS and FAIL.

Reset
REQ-025 SHALL on reset asynchronously force IDLE, loadCount=0, matchCount=0, busy=pass=fail=0, failCode=0, failAdr=failData=0.
REQ-026 SHALL, on reset mid-CHECK, discard progress; table contents need not be cleared but are unreachable until reloaded.

Configuration
REQ-027 SHALL, with `CHK_TIMEOUT_EN defined, count cycles in CHECK, clearing on start and on every matched write; reaching TIMEOUT enters FAIL, failCode=2, failAdr/failData=0.
REQ-028 SHALL, without CHK_TIMEOUT_EN, omit the counter; failCode=2 never produced; CHECK waits indefinitely.
REQ-029 SHALL, with the macro, give mismatch priority over timeout when both occur on the same edge.

Structure
REQ-030 SHALL place state enum and failCode enum in package chk_pkg.
REQ-031 SHALL instantiate sub-module exp_table: DEPTH x (ADR_W+DATA_W) register array, one sync write port, one async read port, no reset.

Verification
REQ-032 Load (0x10,4),(0x11,9); start; writes (0x10,4),(0x11,9) -> pass=1 next cycle, matchCount=2, failCode=0.
REQ-033 Load (0x20,4); start; write (0x20,5) -> fail=1, failCode=1, failAdr=0x20, failData=5, matchCount=0.
REQ-034 After REQ-032 pass, write (0x30,1) -> fail=1, failCode=3, failAdr=0x30; then start -> busy=1, failCode=0.
REQ-035 With CHK_TIMEOUT_EN, TIMEOUT=16: load one entry, start, no writes -> fail=1, failCode=2 exactly 16 cycles after busy rises.
REQ-036 DEPTH=4: five loads then start -> loadCount 4, fifth ignored; reset asserted mid-CHECK between clock edges -> all outputs 0 immediately; start with no loads -> stays IDLE.
